// File: rtl/pkt_fifo.sv
// Whole-packet synchronous FIFO: one entry per packet, registered read data and
// registered status flags, with sticky overflow/underflow and a synchronous flush.
module pkt_fifo #(
    parameter int unsigned FLIT_WIDTH  = 16,
    parameter int unsigned TOTAL_FLITS = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AF_THRESH   = DEPTH - 1,
    localparam int unsigned PKT_W      = FLIT_WIDTH * TOTAL_FLITS,
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wreq,
    input  logic [PKT_W-1:0] din,
    input  logic             rreq,
    output logic [PKT_W-1:0] dout,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = CNT_W - 1;
    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);

    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_wptr, r_rptr, r_count;
    logic [PKT_W-1:0] r_dout;
    logic             r_full, r_empty, r_af, r_ovf, r_unf;

    logic             w_wr_acc, w_rd_acc;
    logic [CNT_W-1:0] w_wptr_d, w_rptr_d, w_count_d;

    // full/empty are registered, so acceptance uses the pre-edge view
    assign w_wr_acc = wreq && !r_full && !flush;
    assign w_rd_acc = rreq && !r_empty && !flush;

    always_comb begin
        w_wptr_d = r_wptr;
        w_rptr_d = r_rptr;
        if (flush) begin
            w_wptr_d = '0;
            w_rptr_d = '0;
        end else begin
            if (w_wr_acc) w_wptr_d = r_wptr + 1'b1;
            if (w_rd_acc) w_rptr_d = r_rptr + 1'b1;
        end
        // Pointer difference modulo 2*DEPTH spans 0..DEPTH exactly
        w_count_d = w_wptr_d - w_rptr_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_d;
            r_rptr  <= w_rptr_d;
            r_count <= w_count_d;
            r_empty <= (w_wptr_d == w_rptr_d);
            r_full  <= (w_wptr_d[AW-1:0] == w_rptr_d[AW-1:0]) &&
                       (w_wptr_d[AW] != w_rptr_d[AW]);
            r_af    <= (w_count_d >= AF_LVL);
            if (w_rd_acc) r_dout <= r_mem[r_rptr[AW-1:0]];
            if (flush) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (wreq && r_full)  r_ovf <= 1'b1;
                if (rreq && r_empty) r_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign dout        = r_dout;
    assign full        = r_full;
    assign empty       = r_empty;
    assign almost_full = r_af;
    assign count       = r_count;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: doc/pkt_fifo.md
# pkt_fifo

Whole-packet synchronous FIFO that buffers complete request/response packets between the network interface and the processing-element side. One entry holds one full packet: head flit, body flits and tail flit. The network interface writes a packet in a single-cycle `wreq` pulse and reads one with a single-cycle `rreq` pulse. Read data is registered, so a packet is available the cycle after it is requested, which matches the interface's read-then-sample sequence.

## Interface
- `FLIT_WIDTH`, 16, bits per flit.
- `TOTAL_FLITS`, 4, flits per packet (head + body + tail); must be ≥ 2.
- `DEPTH`, 4, packet entries; power of two, ≥ 2.
- `AF_THRESH`, DEPTH-1, occupancy at or above which `almost_full` asserts; legal range 1..DEPTH.
- Derived: `PKT_W` = FLIT_WIDTH*TOTAL_FLITS; `CNT_W` = $clog2(DEPTH)+1.

Ports:
- `clk` in 1 — single clock; all state changes on its rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `wreq` in 1 — write request.
- `din` in PKT_W — packet to store, bit-compatible with the packet structs; the head flit occupies the MSBs, the tail flit the LSBs, and the block stores it opaquely.
- `rreq` in 1 — read request.
- `dout` out PKT_W — registered read data.
- `flush` in 1 — synchronous discard of all contents.
- `full` out 1 — occupancy == DEPTH.
- `empty` out 1 — occupancy == 0.
- `almost_full` out 1 — occupancy ≥ AF_THRESH.
- `count` out CNT_W — current occupancy, 0..DEPTH.
- `overflow` out 1 — sticky: a write was attempted while full.
- `underflow` out 1 — sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH×PKT_W array.
- Pointers: write and read pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and wrap bits differ.
- Write accepted: `wreq && !full`.
  - Stores `din` at `wptr`, then increments `wptr`.
  - Wraps from DEPTH-1 to 0 and toggles the wrap bit.
- Read accepted: `rreq && !empty`.
  - `dout` <= mem[`rptr`], then `rptr` increments.
  - When no read is accepted, `dout` holds its last value.
- Simultaneous accepted read and write: both occur and `count` is unchanged.
- At full, `wreq && rreq`: only the read is accepted, because `full` is evaluated before the edge. The write is dropped and `overflow` sets.
- At empty, `wreq && rreq`: only the write is accepted. There is no fall-through, `underflow` sets, and `dout` is unchanged.
- Rejected writes leave the array and pointers untouched. Rejected reads leave `dout` and pointers untouched.
- `flush`:
  - Highest priority; overrides `wreq` and `rreq` in the same cycle.
  - Pointers go to 0, `count` to 0, `empty` to 1, `full` to 0.
  - Clears `overflow` and `underflow`.
  - `dout` and array contents are unchanged.
- `overflow` and `underflow` clear only on reset or `flush`.
- Ordering is strict FIFO, and packet bits are never modified.

## Timing
- Reset values (asynchronous, immediate on `resetn` low):
  - `empty`=1; `full`=0; `almost_full`=0; `count`=0.
  - `overflow`=0; `underflow`=0; `dout`=0; both pointers 0.
  - Array contents are don't-care.
- All status outputs are registered. They reflect accepted operations from the edge at which those operations are sampled.
- Write-to-read latency:
  - Write sampled at edge N → `empty` low after N.
  - `rreq` sampled at edge N+1 → `dout` valid after N+1.
- Read latency: `dout` updates one edge after `rreq` is sampled high. The consumer samples `dout` in the following cycle.
- Back-to-back reads or writes are allowed every cycle; throughput is one packet per cycle per direction.
- `count` and `almost_full` update on the same edge as the pointer change.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Any operation in flight is lost.

## Test plan
- Reset: release `resetn`, no requests → `empty`=1, `full`=0, `count`=0, `dout`=0, both error flags 0.
- Fill/overflow (DEPTH=4):
  - Write packets 0xA001.., 0xA002.., 0xA003.., 0xA004.. on consecutive cycles → `almost_full` high after the 3rd write, `full` and `count`=4 after the 4th.
  - A 5th write → `overflow`=1, `count` stays 4.
  - Reading 4 packets → they return in order A001..A004.
- Simultaneous at full: with `full`=1, pulse `wreq` and `rreq` together → `dout` = oldest packet, `count`=3, `overflow`=1, and the new packet is not stored.
- Empty edge cases:
  - `rreq` alone while empty → `underflow`=1 and `dout` unchanged.
  - Then `wreq` and `rreq` together while empty → `count`=1 and `dout` still unchanged.
  - Next cycle, `rreq` → `dout` = written packet.
- Wrap-around: stream 9 packets with interleaved reads, keeping occupancy at 1–3 → all 9 read back in order, and the pointers wrap twice without a false `full` or `empty`.
- Flush and reset:
  - With `count`=3, assert `flush` together with `wreq` → `count`=0, `empty`=1, error flags cleared, and the write is discarded.
  - Refill to 2, then pull `resetn` low mid-cycle → all outputs go to reset values immediately.
